cover_sat_collector: RTL and testbench
======================================

Name: cover_sat_collector

Overview:
- Sits directly downstream of the fuzz-harness DUT and consumes its flattened coverage vector and assertion vector every cycle.
- Keeps one saturating hit counter per coverage point and latches the first assertion failure (index and cycle).
- On request, streams all counters out over a valid/ready port so the host fuzzer can read one test's coverage without re-simulating.

Parameters:
- N_COVER, 251, number of coverage inputs.
- N_ASSERT, 52, number of assertion inputs.
- CNT_W, 8, width of each saturating hit counter.
- CYC_W, 32, width of the cycle counter and of the failure timestamp.
- CLEAR_ON_DUMP, 1, when 1, all counters are zeroed after the last readout beat.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  sample strobe; low during the harness meta-reset/reset phases.
- cover_in  in  N_COVER  coverage bits from the DUT.
- assert_in  in  N_ASSERT  assertion-violation bits from the DUT.
- clear  in  1  pulse; zero all hit counters.
- dump_req  in  1  pulse; start readout.
- out_valid  out  1  readout beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_index  out  clog2(N_COVER)  coverage point index of the current beat.
- out_count  out  CNT_W  hit count of the current beat.
- out_last  out  1  current beat is index N_COVER-1.
- busy  out  1  high while in DUMP.
- assert_seen  out  1  sticky; an assertion has fired.
- assert_idx  out  clog2(N_ASSERT)  lowest set bit of assert_in in the first failing cycle.
- assert_cycle  out  CYC_W  value of cycle_count in the first failing cycle.
- cycle_count  out  CYC_W  number of enabled cycles since reset; saturates.

Behaviour:
- Reset (synchronous) drives all of the following to 0 on the next clock edge:
  - all hit counters, cycle_count, assert_seen, assert_idx, assert_cycle;
  - out_valid, out_index, busy;
  - state returns to IDLE.
- Reset mid-DUMP aborts the readout; no further beats are produced.
- States:
  - IDLE: sampling.
  - DUMP: counters frozen, readout active.
- Sampling in IDLE with enable=1:
  - for every i with cover_in[i]=1, count[i] increments by 1 and saturates at 2^CNT_W-1 (never wraps);
  - cycle_count increments and saturates at all-ones.
- Sampling with enable=0 or in DUMP: no counter or cycle_count change.
- clear in IDLE: all counters become 0 on the next edge.
  - clear and a cover hit in the same cycle: clear wins, count is 0.
  - clear has no effect on cycle_count or the assertion latch.
  - clear in DUMP is ignored.
- Assertion latch, updated independently of state:
  - if enable=1, assert_in≠0 and assert_seen=0: next edge sets assert_seen=1, assert_idx=lowest set bit of assert_in, assert_cycle=cycle_count (pre-increment value);
  - later failures do not change the latch; only reset clears it.
- IDLE→DUMP on dump_req=1:
  - next cycle busy=1, out_valid=1, out_index=0;
  - dump_req while already in DUMP is ignored;
  - dump_req together with clear: clear applies first, so the dump reads zeros.
- DUMP handshake:
  - out_count is combinationally count[out_index];
  - a beat transfers when out_valid && out_ready;
  - out_valid stays high and out_index/out_count are held stable while out_ready=0;
  - each transfer increments out_index;
  - out_last = (out_index == N_COVER-1).
- Transfer with out_last=1:
  - next cycle state=IDLE, out_valid=0, busy=0, out_index=0;
  - if CLEAR_ON_DUMP=1, all counters are zeroed on that same edge.
- Throughput is one beat per cycle with out_ready held high; a full dump takes N_COVER cycles after dump_req.

Decomposition:
- Shared package cover_collect_pkg holds:
  - the state enum {IDLE, DUMP};
  - width helper constants IDX_W = clog2(N_COVER) and AIDX_W = clog2(N_ASSERT);
  - the saturation max constant.
- One sub-module, cover_counter_bank, instantiated once: the N_COVER×CNT_W saturating counter array with inc vector, clear, freeze and read-index mux.
- The FSM, assertion latch and cycle counter stay in the top level.

Test Plan:
- Saturation: reset, then cover_in[5]=1 for 300 enabled cycles, then dump with out_ready=1 → beat index 5 has count 255; all other beats have count 0; out_last only on index 250.
- Enable gating: cover_in all-ones for 3 cycles with enable=0, then 2 cycles with enable=1, then dump → every count=2; cycle_count=2.
- First assertion latch: after 10 enabled cycles, assert_in=52'h30 → assert_seen=1, assert_idx=4, assert_cycle=10; a later assert_in=1 leaves the latch unchanged.
- Backpressure: dump with out_ready toggling 1,0,0,1 → out_index/out_count held stable during stalls; exactly 251 transfers; busy drops the cycle after the last transfer.
- Clear collision and CLEAR_ON_DUMP: cover_in[0]=1 together with clear=1 → count[0]=0; after a full dump, a second dump returns all zeros.
- Reset mid-dump: reset asserted at beat 100 → next cycle out_valid=0, busy=0, all counters 0; a new dump starts again at index 0.

Source files
------------

// File: rtl/cover_collect_pkg.sv
// rtl/cover_collect_pkg.sv - shared state encoding and width constants for the coverage collector
package cover_collect_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } state_e;

  localparam int N_COVER_DEF  = 251;
  localparam int N_ASSERT_DEF = 52;
  localparam int CNT_W_DEF    = 8;
  localparam int CYC_W_DEF    = 32;

  localparam int IDX_W  = $clog2(N_COVER_DEF);
  localparam int AIDX_W = $clog2(N_ASSERT_DEF);

  localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

endpackage

// File: rtl/cover_counter_bank.sv
// rtl/cover_counter_bank.sv - array of saturating hit counters with clear, freeze and indexed read
import cover_collect_pkg::*;

module cover_counter_bank #(
  parameter int N_COVER = N_COVER_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int IW      = $clog2(N_COVER)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_COVER-1:0] inc,
  input  logic               clear,
  input  logic               freeze,
  input  logic [IW-1:0]      rd_idx,
  output logic [CNT_W-1:0]   rd_count
);

  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q [N_COVER];
  logic [CNT_W-1:0] cnt_d [N_COVER];

  // clear dominates any increment arriving in the same cycle
  always_comb begin
    for (int i = 0; i < N_COVER; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = '0;
      end else if (!freeze && inc[i] && (cnt_q[i] != SAT)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_COVER; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_COVER; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    rd_count = '0;
    if (int'(rd_idx) < N_COVER) begin
      rd_count = cnt_q[rd_idx];
    end
  end

endmodule

// File: rtl/cover_sat_collector.sv
// rtl/cover_sat_collector.sv - per-point coverage hit counting, first-assertion latch and streamed readout
import cover_collect_pkg::*;

module cover_sat_collector #(
  parameter int N_COVER       = N_COVER_DEF,
  parameter int N_ASSERT      = N_ASSERT_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int CYC_W         = CYC_W_DEF,
  parameter int CLEAR_ON_DUMP = 1,
  localparam int IW           = $clog2(N_COVER),
  localparam int AW           = $clog2(N_ASSERT)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [N_COVER-1:0]  cover_in,
  input  logic [N_ASSERT-1:0] assert_in,
  input  logic                clear,
  input  logic                dump_req,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IW-1:0]       out_index,
  output logic [CNT_W-1:0]    out_count,
  output logic                out_last,
  output logic                busy,
  output logic                assert_seen,
  output logic [AW-1:0]       assert_idx,
  output logic [CYC_W-1:0]    assert_cycle,
  output logic [CYC_W-1:0]    cycle_count
);

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               seen_q, seen_d;
  logic [AW-1:0]      aidx_q, aidx_d;
  logic [CYC_W-1:0]   acyc_q, acyc_d;
  logic               bank_clear;
  logic               sampling;
  logic               at_last;
  logic [N_COVER-1:0] bank_inc;

  assign sampling = (state_q == IDLE) && enable;
  assign at_last  = (idx_q == IW'(N_COVER - 1));
  assign bank_inc = sampling ? cover_in : '0;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bank_clear = 1'b0;
    case (state_q)
      IDLE: begin
        // clear lands on the same edge that enters DUMP, so the readout sees zeros
        bank_clear = clear;
        if (dump_req) begin
          state_d = DUMP;
          idx_d   = '0;
        end
      end
      DUMP: begin
        if (out_ready) begin
          if (at_last) begin
            state_d    = IDLE;
            idx_d      = '0;
            bank_clear = (CLEAR_ON_DUMP != 0);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    cyc_d = cyc_q;
    if (sampling && (cyc_q != {CYC_W{1'b1}})) begin
      cyc_d = cyc_q + CYC_W'(1);
    end
  end

  // only the first failing cycle is captured; later failures are ignored until reset
  always_comb begin
    seen_d = seen_q;
    aidx_d = aidx_q;
    acyc_d = acyc_q;
    if (enable && (|assert_in) && !seen_q) begin
      seen_d = 1'b1;
      acyc_d = cyc_q;
      for (int i = N_ASSERT - 1; i >= 0; i--) begin
        if (assert_in[i]) begin
          aidx_d = AW'(i);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cyc_q   <= '0;
      seen_q  <= 1'b0;
      aidx_q  <= '0;
      acyc_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      seen_q  <= seen_d;
      aidx_q  <= aidx_d;
      acyc_q  <= acyc_d;
    end
  end

  cover_counter_bank #(
    .N_COVER (N_COVER),
    .CNT_W   (CNT_W),
    .IW      (IW)
  ) u_bank (
    .clock    (clock),
    .reset    (reset),
    .inc      (bank_inc),
    .clear    (bank_clear),
    .freeze   (state_q == DUMP),
    .rd_idx   (idx_q),
    .rd_count (out_count)
  );

  assign out_valid    = (state_q == DUMP);
  assign busy         = (state_q == DUMP);
  assign out_index    = idx_q;
  assign out_last     = at_last;
  assign assert_seen  = seen_q;
  assign assert_idx   = aidx_q;
  assign assert_cycle = acyc_q;
  assign cycle_count  = cyc_q;

endmodule

// File: tb/tb_cover_sat_collector.sv
// tb/tb_cover_sat_collector.sv - randomized self-checking bench for cover_sat_collector
import cover_collect_pkg::*;

module tb_cover_sat_collector;

  localparam int NC = 251;
  localparam int NA = 52;

  logic              clock = 1'b0;
  logic              reset, enable, clear, dump_req, out_ready;
  logic [NC-1:0]     cover_in;
  logic [NA-1:0]     assert_in;
  logic              out_valid, out_last, busy, assert_seen;
  logic [IDX_W-1:0]  out_index;
  logic [7:0]        out_count;
  logic [AIDX_W-1:0] assert_idx;
  logic [31:0]       assert_cycle, cycle_count;

  int          m_cnt [NC];
  bit          m_dump;
  int          m_idx;
  logic [31:0] m_cyc;
  bit          m_seen;
  int          m_aidx;
  logic [31:0] m_acyc;

  int n_vec, n_err;
  int dump_vals [NC];
  int xfers;

  always #5 clock = ~clock;

  cover_sat_collector dut (
    .clock(clock), .reset(reset), .enable(enable), .cover_in(cover_in),
    .assert_in(assert_in), .clear(clear), .dump_req(dump_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_count(out_count), .out_last(out_last), .busy(busy),
    .assert_seen(assert_seen), .assert_idx(assert_idx),
    .assert_cycle(assert_cycle), .cycle_count(cycle_count)
  );

  function automatic logic [NC-1:0] rand_cover(input int pct);
    logic [NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i] = ($urandom_range(0, 99) < pct);
    return v;
  endfunction

  // Reference model advances by one clock from the inputs currently applied.
  task automatic tick();
    if (reset) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_dump = 0; m_idx = 0; m_cyc = 0; m_seen = 0; m_aidx = 0; m_acyc = 0;
    end else begin
      if (enable && assert_in != 0 && !m_seen) begin
        m_seen = 1;
        m_acyc = m_cyc;
        for (int i = NA - 1; i >= 0; i--) if (assert_in[i]) m_aidx = i;
      end
      if (!m_dump) begin
        if (clear) foreach (m_cnt[i]) m_cnt[i] = 0;
        else if (enable) foreach (m_cnt[i]) if (cover_in[i] && m_cnt[i] < 255) m_cnt[i]++;
        if (enable && m_cyc != 32'hFFFF_FFFF) m_cyc++;
        if (dump_req) begin m_dump = 1; m_idx = 0; end
      end else if (out_ready) begin
        if (m_idx == NC - 1) begin
          m_dump = 0; m_idx = 0;
          foreach (m_cnt[i]) m_cnt[i] = 0;
        end else begin
          m_idx++;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1; enable = 0; clear = 0; dump_req = 0; out_ready = 0;
    cover_in = '0; assert_in = '0;
    tick();
    reset = 0;
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run_dump(input int mode);
    int cyc, pidx, pcnt;
    bit pstall;
    dump_req = 1;
    tick();
    dump_req = 0; clear = 0;
    xfers = 0; pstall = 0; cyc = 0; pidx = 0; pcnt = 0;
    foreach (dump_vals[i]) dump_vals[i] = -1;
    while (m_dump && cyc < 3000) begin
      case (mode)
        0: out_ready = 1;
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = $urandom_range(0, 1);
      endcase
      cover_in = rand_cover(50);
      enable = $urandom_range(0, 1);
      n_vec++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_index !== m_idx[IDX_W-1:0] ||
          out_count !== m_cnt[m_idx][7:0] || out_last !== (m_idx == NC - 1)) begin
        n_err++;
        $display("FAIL dump_beat got valid=%0b busy=%0b idx=%0d cnt=%0d last=%0b want 1 1 %0d %0d %0b",
                 out_valid, busy, out_index, out_count, out_last, m_idx, m_cnt[m_idx], m_idx == NC - 1);
      end
      if (pstall) begin
        n_vec++;
        if (out_index !== pidx[IDX_W-1:0] || out_count !== pcnt[7:0]) begin
          n_err++;
          $display("FAIL stall_hold got idx=%0d cnt=%0d want idx=%0d cnt=%0d",
                   out_index, out_count, pidx, pcnt);
        end
      end
      if (out_valid && out_ready) begin
        dump_vals[out_index] = int'(out_count);
        xfers++;
      end
      pstall = !out_ready;
      pidx = int'(out_index);
      pcnt = int'(out_count);
      tick();
      cyc++;
    end
    out_ready = 0; enable = 0; cover_in = '0;
    n_vec++;
    if (m_dump || busy !== 1'b0 || out_valid !== 1'b0 || out_index !== '0) begin
      n_err++;
      $display("FAIL dump_end got busy=%0b valid=%0b idx=%0d want busy=0 valid=0 idx=0 (model_dump=%0b)",
               busy, out_valid, out_index, m_dump);
    end
  endtask

  task automatic test_reset();
    enable = 1; cover_in = rand_cover(50); assert_in = 52'h8; clear = 0; dump_req = 0;
    reset = 0; out_ready = 0;
    repeat (5) tick();
    dump_req = 1; tick(); dump_req = 0;
    apply_reset();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0b want 0", busy); end
    n_vec++; if (out_index !== '0) begin n_err++; $display("FAIL rst_index got %0d want 0", out_index); end
    n_vec++; if (cycle_count !== 32'd0) begin n_err++; $display("FAIL rst_cycle got %0d want 0", cycle_count); end
    n_vec++; if (assert_seen !== 1'b0) begin n_err++; $display("FAIL rst_seen got %0b want 0", assert_seen); end
    n_vec++; if (assert_idx !== '0) begin n_err++; $display("FAIL rst_aidx got %0d want 0", assert_idx); end
    n_vec++; if (assert_cycle !== 32'd0) begin n_err++; $display("FAIL rst_acyc got %0d want 0", assert_cycle); end
  endtask

  task automatic test_saturation();
    int bad;
    apply_reset();
    cover_in[5] = 1'b1; enable = 1;
    repeat (300) tick();
    enable = 0; cover_in = '0;
    run_dump(0);
    n_vec++; if (dump_vals[5] !== 255) begin n_err++; $display("FAIL sat_count got %0d want 255", dump_vals[5]); end
    bad = 0;
    for (int i = 0; i < NC; i++) if (i != 5 && dump_vals[i] != 0) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL sat_others got %0d nonzero want 0", bad); end
    n_vec++; if (xfers != NC) begin n_err++; $display("FAIL sat_xfers got %0d want %0d", xfers, NC); end
  endtask

  task automatic test_enable_gating();
    int bad;
    apply_reset();
    cover_in = '1;
    enable = 0; repeat (3) tick();
    enable = 1; repeat (2) tick();
    enable = 0; cover_in = '0;
    n_vec++; if (cycle_count !== 32'd2) begin n_err++; $display("FAIL en_cycle got %0d want 2", cycle_count); end
    run_dump(0);
    bad = 0;
    foreach (dump_vals[i]) if (dump_vals[i] != 2) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL en_counts got %0d beats != 2 want 0", bad); end
    n_vec++; if (cycle_count !== 32'd2) begin n_err++; $display("FAIL en_cycle_after_dump got %0d want 2", cycle_count); end
  endtask

  task automatic test_assert_latch();
    apply_reset();
    enable = 1;
    repeat (10) begin cover_in = rand_cover(20); tick(); end
    assert_in = 52'h30; tick();
    assert_in = '0;
    n_vec++; if (assert_seen !== 1'b1) begin n_err++; $display("FAIL as_seen got %0b want 1", assert_seen); end
    n_vec++; if (assert_idx !== 6'd4) begin n_err++; $display("FAIL as_idx got %0d want 4", assert_idx); end
    n_vec++; if (assert_cycle !== 32'd10) begin n_err++; $display("FAIL as_cycle got %0d want 10", assert_cycle); end
    assert_in = 52'h1; tick();
    assert_in = '0; enable = 0; cover_in = '0;
    n_vec++; if (assert_idx !== 6'd4 || assert_cycle !== 32'd10 || assert_seen !== 1'b1) begin
      n_err++; $display("FAIL as_hold got idx=%0d cyc=%0d seen=%0b want 4 10 1", assert_idx, assert_cycle, assert_seen);
    end
    n_vec++; if (cycle_count !== 32'd12) begin n_err++; $display("FAIL as_cyc_count got %0d want 12", cycle_count); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    repeat (50) begin enable = ($urandom_range(0, 3) != 0); cover_in = rand_cover(40); tick(); end
    enable = 0; cover_in = '0;
    run_dump(1);
    n_vec++; if (xfers != NC) begin n_err++; $display("FAIL bp_xfers got %0d want %0d", xfers, NC); end
  endtask

  task automatic test_clear_collision();
    int bad;
    apply_reset();
    enable = 1;
    repeat (20) begin cover_in = rand_cover(50); tick(); end
    cover_in = '0; cover_in[0] = 1'b1; clear = 1; tick();
    clear = 0; enable = 0; cover_in = '0;
    run_dump(0);
    n_vec++; if (dump_vals[0] !== 0) begin n_err++; $display("FAIL clr_count0 got %0d want 0", dump_vals[0]); end
    enable = 1;
    repeat (15) begin cover_in = rand_cover(60); tick(); end
    enable = 0; cover_in = '0;
    run_dump(2);
    run_dump(0);
    bad = 0;
    foreach (dump_vals[i]) if (dump_vals[i] != 0) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL clr_on_dump got %0d nonzero want 0", bad); end
    enable = 1;
    repeat (15) begin cover_in = rand_cover(60); tick(); end
    enable = 0; cover_in = '0;
    clear = 1;
    run_dump(0);
    bad = 0;
    foreach (dump_vals[i]) if (dump_vals[i] != 0) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL clr_with_dump got %0d nonzero want 0", bad); end
  endtask

  task automatic test_reset_mid_dump();
    int budget, bad;
    apply_reset();
    enable = 1;
    repeat (30) begin cover_in = rand_cover(50); tick(); end
    enable = 0; cover_in = '0;
    dump_req = 1; tick(); dump_req = 0;
    out_ready = 1; budget = 0;
    while (m_idx < 100 && budget < 500) begin tick(); budget++; end
    n_vec++; if (out_index !== 8'd100 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_reach got idx=%0d valid=%0b want 100 1", out_index, out_valid);
    end
    reset = 1; tick(); reset = 0; out_ready = 0;
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_abort got valid=%0b busy=%0b want 0 0", out_valid, busy);
    end
    repeat (3) tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_beats got %0b want 0", out_valid); end
    run_dump(0);
    bad = 0;
    foreach (dump_vals[i]) if (dump_vals[i] != 0) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL mid_zero got %0d nonzero want 0", bad); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      repeat (150) begin
        enable = ($urandom_range(0, 9) < 7);
        cover_in = rand_cover(30);
        clear = ($urandom_range(0, 99) < 3);
        assert_in = '0;
        if ($urandom_range(0, 99) < 5)
          for (int i = 0; i < NA; i++) assert_in[i] = ($urandom_range(0, 9) == 0);
        tick();
      end
      clear = 0; assert_in = '0; enable = 0; cover_in = '0;
      n_vec++; if (cycle_count !== m_cyc) begin n_err++; $display("FAIL rnd_cycle got %0d want %0d", cycle_count, m_cyc); end
      n_vec++; if (assert_seen !== m_seen || assert_idx !== m_aidx[AIDX_W-1:0] || assert_cycle !== m_acyc) begin
        n_err++; $display("FAIL rnd_latch got seen=%0b idx=%0d cyc=%0d want %0b %0d %0d",
                          assert_seen, assert_idx, assert_cycle, m_seen, m_aidx, m_acyc);
      end
      run_dump(2);
      n_vec++; if (xfers != NC) begin n_err++; $display("FAIL rnd_xfers got %0d want %0d", xfers, NC); end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1; enable = 0; clear = 0; dump_req = 0; out_ready = 0;
    cover_in = '0; assert_in = '0;
    tick();
    test_reset();
    test_saturation();
    test_enable_gating();
    test_assert_latch();
    test_backpressure();
    test_clear_collision();
    test_reset_mid_dump();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
